// File: rtl/cpu_pkg.sv
// cpu_pkg: shared core widths, opcode field bounds, opcode encodings and fetch-state enum
package cpu_pkg;
  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 32;
  localparam int OPC_HI  = 31;
  localparam int OPC_LO  = 26;
  localparam logic [5:0] OPC_ALU     = 6'b000000;
  localparam logic [5:0] OPC_ALUI    = 6'b000001;
  localparam logic [5:0] OPC_LOAD    = 6'b000010;
  localparam logic [5:0] OPC_STORE   = 6'b000011;
  localparam logic [5:0] OPC_BRANCH  = 6'b000100;
  localparam logic [5:0] OPC_JUMP    = 6'b000101;
  localparam logic [5:0] HALT_OPCODE = 6'b111111;
  typedef enum logic [1:0] {RESET, RUN, HALTED} fetch_state_t;
endpackage

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: PC sequencer with one-entry registered output stage, redirect and HALT/resume
// Ports: clk/rst_n (sync, active-low); imem_addr/imem_instr to combinational instruction memory;
//        if_valid/if_ready/if_instr/if_pc handshake to decode; redirect_valid/redirect_pc from execute;
//        resume pulse leaves HALTED; halted flags the HALTED state.
module instr_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [5:0] HALT_OPCODE = cpu_pkg::HALT_OPCODE
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               resume,
  output logic               halted
);
  fetch_state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, ipc_q, ipc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic valid_q, valid_d;
  logic slot_free, is_halt;
  assign slot_free = !valid_q || if_ready;
  assign is_halt = imem_instr[OPC_HI:OPC_LO] == HALT_OPCODE;
  assign imem_addr = pc_q;
  assign if_valid = valid_q;
  assign if_instr = instr_q;
  assign if_pc = ipc_q;
  assign halted = state_q == HALTED;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d = ipc_q;
    if (state_q == RESET) begin
      state_d = RUN;
    end else if (redirect_valid) begin
      // flush: the word read this cycle belongs to the abandoned path
      state_d = RUN;
      pc_d = redirect_pc;
      valid_d = 1'b0;
    end else if (state_q == HALTED) begin
      // let a pending word finish its handshake, but never capture a new one
      valid_d = valid_q && !if_ready;
      state_d = resume ? RUN : HALTED;
    end else if (slot_free) begin
      valid_d = 1'b1;
      instr_d = imem_instr;
      ipc_d = pc_q;
      // pc stays on the HALT word so resume refetches it
      pc_d = is_halt ? pc_q : pc_q + 1'b1;
      state_d = is_halt ? HALTED : RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RESET;
      pc_q <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= '0;
      ipc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q <= ipc_d;
    end
  end
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: directed scenarios plus randomized run against a behavioural fetch model
module tb_instr_fetch_ctrl;
  logic clk = 0;
  logic rst_n = 0;
  logic [15:0] imem_addr;
  logic [31:0] imem_instr;
  logic if_valid;
  logic if_ready = 1;
  logic [31:0] if_instr;
  logic [15:0] if_pc;
  logic redirect_valid = 0;
  logic [15:0] redirect_pc = 0;
  logic resume = 0;
  logic halted;
  logic halt_en = 0;
  logic [15:0] halt_addr = 0;
  logic [9:0] salt = 0;
  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_f(input logic [15:0] a, input logic he, input logic [15:0] ha,
                                        input logic [9:0] s);
    logic [5:0] op;
    op = (he && a == ha) ? 6'h3F : {1'b0, a[4:0]};
    return {op, s ^ a[9:0], a};
  endfunction

  assign imem_instr = rom_f(imem_addr, halt_en, halt_addr, salt);

  instr_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .resume(resume), .halted(halted)
  );

  // Reference: which address is next to fetch, what decode currently sees, and whether fetch is parked
  logic [15:0] m_pc, m_ipc;
  logic [31:0] m_instr, m_word;
  logic m_v, m_halt, m_boot, m_free;
  always @(posedge clk) begin
    m_word = rom_f(m_pc, halt_en, halt_addr, salt);
    m_free = !m_v || if_ready;
    if (!rst_n) begin
      m_pc <= 16'h0000; m_v <= 0; m_instr <= 0; m_ipc <= 0; m_halt <= 0; m_boot <= 1;
    end else if (m_boot) begin
      m_boot <= 0;
    end else if (redirect_valid) begin
      m_pc <= redirect_pc; m_v <= 0; m_halt <= 0;
    end else if (m_halt) begin
      if (m_free) m_v <= 0;
      if (resume) m_halt <= 0;
    end else if (m_free) begin
      m_v <= 1; m_instr <= m_word; m_ipc <= m_pc;
      if (m_word[31:26] == 6'h3F) m_halt <= 1;
      else m_pc <= m_pc + 16'd1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; redirect_valid = 0; resume = 0;
    tick(); tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_reset();
    if_ready = 1; halt_en = 0;
    rst_n = 0;
    tick(); tick();
    total_cnt++;
    if ({if_valid, if_pc, if_instr, imem_addr, halted} !== {1'b0, 16'h0, 32'h0, 16'h0, 1'b0})
      $display("FAIL reset_values got v=%0b pc=%h instr=%h addr=%h halted=%0b want 0/0/0/0/0",
               if_valid, if_pc, if_instr, imem_addr, halted);
    else pass_cnt++;
    rst_n = 1;
    tick();
    total_cnt++;
    if ({if_valid, imem_addr} !== {1'b0, 16'h0})
      $display("FAIL reset_cycle got v=%0b addr=%h want v=0 addr=0000", if_valid, imem_addr);
    else pass_cnt++;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 4; i++) begin
      tick();
      total_cnt++;
      if ({if_valid, if_pc, if_instr} !== {1'b1, 16'(i), rom_f(16'(i), 0, 0, salt)})
        $display("FAIL stream_%0d got v=%0b pc=%h instr=%h want v=1 pc=%h instr=%h", i,
                 if_valid, if_pc, if_instr, 16'(i), rom_f(16'(i), 0, 0, salt));
      else pass_cnt++;
    end
    total_cnt++;
    if (imem_addr !== 16'h0004) $display("FAIL stream_addr got %h want 0004", imem_addr);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    halt_en = 0; if_ready = 1;
    do_reset();
    tick(); tick();
    if_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if ({if_valid, if_pc, if_instr, imem_addr} !== {1'b1, 16'h1, rom_f(16'h1, 0, 0, salt), 16'h2})
        $display("FAIL stall_%0d got v=%0b pc=%h instr=%h addr=%h want v=1 pc=0001 addr=0002",
                 i, if_valid, if_pc, if_instr, imem_addr);
      else pass_cnt++;
    end
    if_ready = 1;
    for (int i = 2; i < 4; i++) begin
      tick();
      total_cnt++;
      if ({if_valid, if_pc, if_instr} !== {1'b1, 16'(i), rom_f(16'(i), 0, 0, salt)})
        $display("FAIL after_stall_%0d got v=%0b pc=%h instr=%h want v=1 pc=%h", i,
                 if_valid, if_pc, if_instr, 16'(i));
      else pass_cnt++;
    end
  endtask

  task automatic test_redirect();
    halt_en = 0; if_ready = 1;
    do_reset();
    tick(); tick();
    redirect_valid = 1; redirect_pc = 16'h0004;
    tick();
    redirect_valid = 0;
    total_cnt++;
    if ({if_valid, imem_addr} !== {1'b0, 16'h0004})
      $display("FAIL redirect_bubble got v=%0b addr=%h want v=0 addr=0004", if_valid, imem_addr);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 16'h4, rom_f(16'h4, 0, 0, salt)})
      $display("FAIL redirect_target got v=%0b pc=%h instr=%h want v=1 pc=0004 instr=%h",
               if_valid, if_pc, if_instr, rom_f(16'h4, 0, 0, salt));
    else pass_cnt++;
  endtask

  task automatic test_halt_resume();
    halt_en = 1; halt_addr = 16'h2; if_ready = 1;
    do_reset();
    tick(); tick(); tick();
    total_cnt++;
    if ({if_valid, if_pc, if_instr[31:26], halted} !== {1'b1, 16'h2, 6'h3F, 1'b1})
      $display("FAIL halt_capture got v=%0b pc=%h op=%h halted=%0b want v=1 pc=0002 op=3f halted=1",
               if_valid, if_pc, if_instr[31:26], halted);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      tick();
      total_cnt++;
      if ({if_valid, halted, imem_addr} !== {1'b0, 1'b1, 16'h2})
        $display("FAIL halt_idle_%0d got v=%0b halted=%0b addr=%h want v=0 halted=1 addr=0002",
                 i, if_valid, halted, imem_addr);
      else pass_cnt++;
    end
    resume = 1;
    tick();
    resume = 0;
    total_cnt++;
    if ({if_valid, halted} !== 2'b00)
      $display("FAIL resume_state got v=%0b halted=%0b want 0/0", if_valid, halted);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({if_valid, if_pc, halted} !== {1'b1, 16'h2, 1'b1})
      $display("FAIL resume_refetch got v=%0b pc=%h halted=%0b want v=1 pc=0002 halted=1",
               if_valid, if_pc, halted);
    else pass_cnt++;
    redirect_valid = 1; redirect_pc = 16'h0005; resume = 1;
    tick();
    redirect_valid = 0; resume = 0;
    total_cnt++;
    if ({if_valid, halted, imem_addr} !== {1'b0, 1'b0, 16'h5})
      $display("FAIL redirect_vs_resume got v=%0b halted=%0b addr=%h want v=0 halted=0 addr=0005",
               if_valid, halted, imem_addr);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({if_valid, if_pc} !== {1'b1, 16'h5})
      $display("FAIL redirect_vs_resume_target got v=%0b pc=%h want v=1 pc=0005", if_valid, if_pc);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    halt_en = 0; if_ready = 1;
    redirect_valid = 1; redirect_pc = 16'hFFFF;
    tick();
    redirect_valid = 0;
    tick();
    total_cnt++;
    if ({if_valid, if_pc, imem_addr} !== {1'b1, 16'hFFFF, 16'h0000})
      $display("FAIL wrap_top got v=%0b pc=%h addr=%h want v=1 pc=ffff addr=0000", if_valid, if_pc, imem_addr);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 16'h0, rom_f(16'h0, 0, 0, salt)})
      $display("FAIL wrap_zero got v=%0b pc=%h instr=%h want v=1 pc=0000", if_valid, if_pc, if_instr);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_stall();
    halt_en = 1; halt_addr = 16'h1; if_ready = 1;
    do_reset();
    tick(); tick();
    if_ready = 0;
    tick();
    rst_n = 0;
    tick();
    total_cnt++;
    if ({if_valid, imem_addr, halted, if_instr, if_pc} !== {1'b0, 16'h0, 1'b0, 32'h0, 16'h0})
      $display("FAIL reset_mid_stall got v=%0b addr=%h halted=%0b instr=%h pc=%h want all 0",
               if_valid, imem_addr, halted, if_instr, if_pc);
    else pass_cnt++;
    rst_n = 1; if_ready = 1; halt_en = 0;
    tick();
  endtask

  task automatic test_random();
    halt_en = 1; halt_addr = 16'($urandom_range(3, 20)); if_ready = 1;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if_ready = $urandom_range(0, 3) != 0;
      redirect_valid = $urandom_range(0, 11) == 0;
      redirect_pc = ($urandom_range(0, 7) == 0) ? 16'hFFFE : 16'($urandom_range(0, 40));
      resume = $urandom_range(0, 5) == 0;
      tick();
      total_cnt++;
      if ({if_valid, if_pc, if_instr} !== {m_v, m_ipc, m_instr})
        $display("FAIL rand_stage_%0d got v=%0b pc=%h instr=%h want v=%0b pc=%h instr=%h",
                 c, if_valid, if_pc, if_instr, m_v, m_ipc, m_instr);
      else pass_cnt++;
      total_cnt++;
      if ({imem_addr, halted} !== {m_pc, m_halt})
        $display("FAIL rand_ctrl_%0d got addr=%h halted=%0b want addr=%h halted=%0b",
                 c, imem_addr, halted, m_pc, m_halt);
      else pass_cnt++;
    end
    redirect_valid = 0; resume = 0;
  endtask

  initial begin
    salt = 10'($urandom);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt_resume();
    test_wrap();
    test_reset_mid_stall();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
